// File: rtl/ascon_nmr_guard_if.sv
// Launch/replica/result bus of the ASCON N-modular-redundancy guard.
// master = protocol side and replicas, slave = the guard itself.
interface ascon_nmr_guard_if #(
   parameter int NR = 3,
   parameter int W  = 40,
   parameter int TW = 128,
   parameter int CW = 8
) ();
   logic             start;
   logic             rep_start;
   logic [NR-1:0]    rep_ready;
   logic [NR*W-1:0]  rep_data;
   logic [NR*TW-1:0] rep_tag;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data;
   logic [TW-1:0]    out_tag;
   logic             fault_flag;
   logic [NR-1:0]    fault_mask;
   logic [3:0]       retry_count;
   logic [NR*CW-1:0] fault_cnt;

   modport master (
      output start, rep_ready, rep_data, rep_tag, out_ready,
      input  rep_start, busy, out_valid, out_data, out_tag,
             fault_flag, fault_mask, retry_count, fault_cnt
   );

   modport slave (
      input  start, rep_ready, rep_data, rep_tag, out_ready,
      output rep_start, busy, out_valid, out_data, out_tag,
             fault_flag, fault_mask, retry_count, fault_cnt
   );
endinterface

// File: rtl/ascon_nmr_guard.sv
// N-modular-redundancy guard: launches NR replica cores, captures their results,
// votes bitwise over data and tag, retries on lost quorum, and counts faults per replica.
module ascon_nmr_guard #(
   parameter int NR        = 3,
   parameter int W         = 40,
   parameter int TW        = 128,
   parameter int TIMEOUT   = 64,
   parameter int MAX_RETRY = 2,
   parameter int CW        = 8
) (
   input logic              clk,
   input logic              rst,
   ascon_nmr_guard_if.slave bus
);
   localparam int         TMW    = $clog2(TIMEOUT);
   localparam int         QUORUM = NR / 2 + 1;
   localparam logic [3:0] MAX_R  = 4'(MAX_RETRY);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, VOTE, OUT} state_t;

   state_t           state_q, state_d;
   logic [NR-1:0]    latch_q, latch_d, cap_en, agree, mask_d, col;
   logic [NR*W-1:0]  cap_data_q;
   logic [NR*TW-1:0] cap_tag_q;
   logic [TMW-1:0]   tmo_q;
   logic [3:0]       retry_q;
   logic [W-1:0]     vote_data;
   logic [TW-1:0]    vote_tag;
   logic             quorum, retry_ok;

   logic [W-1:0]     out_data_q;
   logic [TW-1:0]    out_tag_q;
   logic             fault_flag_q;
   logic [NR-1:0]    fault_mask_q;
   logic [3:0]       retry_count_q;
   logic [NR*CW-1:0] fault_cnt_q;

   function automatic int popcount(input logic [NR-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < NR; i++) if (v[i]) n++;
      return n;
   endfunction

   function automatic logic majority(input logic [NR-1:0] v);
      return popcount(v) > NR / 2;
   endfunction

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // Unlatched replicas contribute zeros to the vote but still count toward NR.
   always_comb begin
      vote_data = '0;
      vote_tag  = '0;
      col       = '0;
      agree     = '0;
      for (int b = 0; b < W; b++) begin
         for (int i = 0; i < NR; i++) col[i] = latch_q[i] & cap_data_q[i*W + b];
         vote_data[b] = majority(col);
      end
      for (int b = 0; b < TW; b++) begin
         for (int i = 0; i < NR; i++) col[i] = latch_q[i] & cap_tag_q[i*TW + b];
         vote_tag[b] = majority(col);
      end
      for (int i = 0; i < NR; i++)
         agree[i] = latch_q[i] && (cap_data_q[i*W +: W] == vote_data)
                               && (cap_tag_q[i*TW +: TW] == vote_tag);
      quorum   = popcount(agree) >= QUORUM;
      mask_d   = quorum ? ~agree : '1;
      retry_ok = retry_q < MAX_R;
   end

   always_comb begin
      state_d = state_q;
      latch_d = latch_q;
      cap_en  = '0;
      case (state_q)
         IDLE:   if (bus.start) state_d = LAUNCH;
         LAUNCH: begin
            // A replica finishing in the launch cycle itself is accepted.
            latch_d = bus.rep_ready;
            cap_en  = bus.rep_ready;
            state_d = WAIT;
         end
         WAIT: begin
            cap_en  = bus.rep_ready & ~latch_q;
            latch_d = latch_q | bus.rep_ready;
            if ((&latch_d) || (tmo_q == TMW'(TIMEOUT - 1))) state_d = VOTE;
         end
         VOTE:   state_d = (quorum || !retry_ok) ? OUT : LAUNCH;
         OUT:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         latch_q       <= '0;
         cap_data_q    <= '0;
         cap_tag_q     <= '0;
         tmo_q         <= '0;
         retry_q       <= '0;
         out_data_q    <= '0;
         out_tag_q     <= '0;
         fault_flag_q  <= 1'b0;
         fault_mask_q  <= '0;
         retry_count_q <= '0;
         fault_cnt_q   <= '0;
      end else begin
         latch_q <= latch_d;
         for (int i = 0; i < NR; i++) begin
            if (cap_en[i]) begin
               cap_data_q[i*W +: W]   <= bus.rep_data[i*W +: W];
               cap_tag_q[i*TW +: TW]  <= bus.rep_tag[i*TW +: TW];
            end
         end
         case (state_q)
            IDLE:   if (bus.start) retry_q <= '0;
            LAUNCH: tmo_q <= '0;
            WAIT:   tmo_q <= tmo_q + 1'b1;
            VOTE: begin
               // Result registers and counters move only on the final vote.
               if (quorum || !retry_ok) begin
                  out_data_q    <= quorum ? vote_data : '0;
                  out_tag_q     <= quorum ? vote_tag  : '0;
                  fault_flag_q  <= !quorum;
                  fault_mask_q  <= mask_d;
                  retry_count_q <= retry_q;
                  for (int i = 0; i < NR; i++)
                     if (mask_d[i]) fault_cnt_q[i*CW +: CW] <= sat_inc(fault_cnt_q[i*CW +: CW]);
               end else begin
                  retry_q <= retry_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.rep_start   = (state_q == LAUNCH);
   assign bus.busy        = (state_q != IDLE);
   assign bus.out_valid   = (state_q == OUT);
   assign bus.out_data    = out_data_q;
   assign bus.out_tag     = out_tag_q;
   assign bus.fault_flag  = fault_flag_q;
   assign bus.fault_mask  = fault_mask_q;
   assign bus.retry_count = retry_count_q;
   assign bus.fault_cnt   = fault_cnt_q;
endmodule

// File: doc/ascon_nmr_guard.md
# ascon_nmr_guard

Parametrised N-modular-redundancy guard for the ASCON datapath: launches NR replica cores (encryption or decryption instances), captures each replica's result as it completes, and forms a bitwise majority over data and tag. It checks the majority for a quorum, retries on loss of quorum, and keeps per-replica saturating fault counters. It sits between the protocol controller and the replicated Encryption/Decryption instances. It replaces fixed triple voting with configurable redundancy, a timeout, retry, and a valid/ready output handshake.

## Interface
- NR, 3: replica count; odd, 3..7
- W, 40: data (ciphertext/plaintext) width
- TW, 128: tag width
- TIMEOUT, 64: max WAIT cycles before voting on replicas already complete; >=2
- MAX_RETRY, 2: re-launches allowed after quorum failure; 0..15
- CW, 8: per-replica fault counter width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  operation request; accepted only when busy=0
- rep_start  out  1  one-cycle launch pulse, wired to all replicas
- rep_ready  in  NR  per-replica completion level/pulse
- rep_data  in  NR*W  replica i data at [i*W +: W]
- rep_tag  in  NR*TW  replica i tag at [i*TW +: TW]
- busy  out  1  high from the start-accept edge until the out handshake completes
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  downstream accept
- out_data  out  W  voted data; zero when fault_flag=1
- out_tag  out  TW  voted tag; zero when fault_flag=1
- fault_flag  out  1  quorum not reached after MAX_RETRY retries
- fault_mask  out  NR  replicas that disagreed with the vote or were not ready, last operation
- retry_count  out  4  retries used, last operation
- fault_cnt  out  NR*CW  saturating per-replica fault counts, replica i at [i*CW +: CW]

## Operation
- States: IDLE, LAUNCH, WAIT, VOTE, OUT.
- IDLE: start=1 -> LAUNCH, busy=1, retry counter cleared.
- LAUNCH: rep_start=1 for exactly this cycle. Clear ready latches and the timeout counter. -> WAIT.
- WAIT: on the first cycle rep_ready[i]=1, set latch i and capture rep_data/rep_tag slice i. Later changes on that replica are ignored. Go to VOTE when all NR latches are set, or when the timeout counter reaches TIMEOUT-1.
- VOTE, one cycle:
  - Per bit, majority = 1 when more than NR/2 of the latched replicas hold 1. Unlatched replicas count as 0.
  - agree_i = latched_i AND (data_i, tag_i) equals the voted (data, tag).
  - If popcount(agree) >= NR/2+1: register the voted values, fault_flag=0, -> OUT.
  - Else if retry < MAX_RETRY: retry+1, -> LAUNCH.
  - Else: out_data/out_tag=0, fault_flag=1, -> OUT.
- Quorum is counted over NR, not over the latched replicas.
- On exit to OUT:
  - fault_mask = ~agree. When fault_flag=1, fault_mask = all-ones.
  - fault_cnt[i] += 1, saturating at 2^CW-1, for each set mask bit.
  - retry_count = retries used.
- OUT: out_valid=1. out_data, out_tag, fault_flag, fault_mask and retry_count are stable until out_valid&out_ready. On that handshake -> IDLE, busy=0.
- Counters and the mask are not updated on the intermediate quorum failures that lead to a retry.

## Timing
- Reset: every output and every internal register is 0, including fault_cnt, fault_mask, retry_count and the ready latches. State = IDLE.
- Reset mid-operation aborts immediately, with no out_valid.
- start is sampled at edge E0 (state IDLE). rep_start is high in the cycle E0..E1.
- A rep_ready sampled at edge E1 or later counts; a rep_ready asserted in the same cycle as rep_start also counts.
- Fault-free latency: all replicas ready at edge Ek -> VOTE during cycle Ek..Ek+1 -> out_valid high from edge Ek+1.
- Timeout: VOTE is entered at latest TIMEOUT cycles after entering WAIT.
- Each retry adds 1 LAUNCH cycle plus the replica latency.
- Back-to-back: a start held high through the OUT handshake is accepted at the first edge in IDLE, i.e. the edge after the handshake. A start while busy=1 is ignored, not queued.
- out_ready with out_valid=0 has no effect.
- Counter saturation: at 2^CW-1 the count stays put and does not wrap.

## Test plan
- NR=3, all replicas return data=0x0123456789, tag=0xA5..A5 at the same cycle. Required: out_valid one cycle after VOTE, fault_flag=0, fault_mask=000, retry_count=0, fault_cnt all 0.
- NR=5, replica 2 tag bit 0 flipped. Required: voted values correct, fault_mask=00100, fault_cnt[2]=1, others 0.
- NR=3, replica 1 never asserts rep_ready, TIMEOUT=16. Required: VOTE reached 16 cycles after entering WAIT, correct output, fault_mask=010.
- NR=3, all three replicas return different data on every launch, MAX_RETRY=2. Required: exactly 3 rep_start pulses, fault_flag=1, out_data=0, out_tag=0, retry_count=2, fault_mask=111, each fault_cnt=1.
- Disagreement on the first attempt only, agreement on retry. Required: 2 rep_start pulses, fault_flag=0, retry_count=1, fault_mask reflects the second attempt only.
- CW=2, replica 0 faulty for 5 consecutive operations. Required: fault_cnt[0] saturates at 3.
- With out_ready held low for 10 cycles, outputs stay stable and a start pulse is ignored.
- rst asserted in WAIT: all outputs go to 0 at once and the FSM returns to IDLE.
